// File: rtl/demux_destinos_pkg.sv
// Shared defaults for the destination demultiplexer: widths, FIFO sizing and
// the highest legal destination tag.
package demux_destinos_pkg;

   localparam int DFLT_DATA_W      = 8;
   localparam int DFLT_DEST_W      = 4;
   localparam int DFLT_DEPTH       = 4;
   localparam int DFLT_ALMOST_FULL = 3;

   // Tags above this value address no destination and are dropped.
   localparam int DEST_MAX = 3;
   localparam int N_DEST   = DEST_MAX + 1;

endpackage

// File: rtl/demux_destinos_fifo_destino.sv
// Single first-word-fall-through FIFO for one destination. The head word is
// visible on data_out whenever the FIFO is not empty; otherwise data_out is 0.
module fifo_destino #(
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 4,
   localparam int AW     = $clog2(DEPTH),
   localparam int CW     = AW + 1
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              empty,
   output logic              full,
   output logic [CW-1:0]     count
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic              do_pop;
   logic              do_push;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   // A push into a full FIFO is still accepted when the same edge frees a slot.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: a zero count hides every entry.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= data_in;
   end

   assign data_out = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/demux_destinos.sv
// Steers the arbitrated word stream into four per-destination FWFT FIFOs and
// reports illegal tags, dropped words and near-full back-pressure.
module demux_destinos
   import demux_destinos_pkg::*;
#(
   parameter int DATA_W      = DFLT_DATA_W,
   parameter int DEST_W      = DFLT_DEST_W,
   parameter int DEPTH       = DFLT_DEPTH,
   parameter int ALMOST_FULL = DFLT_ALMOST_FULL
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              push_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic [DEST_W-1:0] dest_in,
   output logic              pause_out,
   input  logic              pop0,
   input  logic              pop1,
   input  logic              pop2,
   input  logic              pop3,
   output logic [DATA_W-1:0] data_out0,
   output logic [DATA_W-1:0] data_out1,
   output logic [DATA_W-1:0] data_out2,
   output logic [DATA_W-1:0] data_out3,
   output logic              empty0,
   output logic              empty1,
   output logic              empty2,
   output logic              empty3,
   output logic              full0,
   output logic              full1,
   output logic              full2,
   output logic              full3,
   output logic              err_dest,
   output logic              err_overflow
);

   localparam int CW = $clog2(DEPTH) + 1;

   // Handshake: push_in has no ready; the arbiter must stop pushing the cycle
   // after pause_out rises, and the DEPTH-ALMOST_FULL spare slots absorb the
   // word already in flight. Any word that still finds no room is dropped.

   logic [N_DEST-1:0] pop_v;
   logic [N_DEST-1:0] push_en;
   logic [N_DEST-1:0] empty_v;
   logic [N_DEST-1:0] full_v;
   logic [DATA_W-1:0] data_out_v [N_DEST];
   logic [CW-1:0]     count_v    [N_DEST];
   logic [1:0]        dest_idx;
   logic              dest_legal;
   logic              overflow_now;

   assign pop_v      = {pop3, pop2, pop1, pop0};
   assign dest_idx   = dest_in[1:0];
   assign dest_legal = (dest_in <= DEST_W'(DEST_MAX));

   assign overflow_now = push_in && dest_legal && full_v[dest_idx] && !pop_v[dest_idx];

   for (genvar k = 0; k < N_DEST; k++) begin : g_fifo
      assign push_en[k] = push_in && dest_legal && (dest_idx == 2'(k));

      fifo_destino #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk      (clk),
         .reset_L  (reset_L),
         .push     (push_en[k]),
         .pop      (pop_v[k]),
         .data_in  (data_in),
         .data_out (data_out_v[k]),
         .empty    (empty_v[k]),
         .full     (full_v[k]),
         .count    (count_v[k])
      );
   end

   always_comb begin
      pause_out = 1'b0;
      for (int k = 0; k < N_DEST; k++) begin
         if (count_v[k] >= CW'(ALMOST_FULL)) pause_out = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         err_dest     <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         err_dest     <= push_in && !dest_legal;
         err_overflow <= overflow_now;
      end
   end

   assign data_out0 = data_out_v[0];
   assign data_out1 = data_out_v[1];
   assign data_out2 = data_out_v[2];
   assign data_out3 = data_out_v[3];
   assign empty0    = empty_v[0];
   assign empty1    = empty_v[1];
   assign empty2    = empty_v[2];
   assign empty3    = empty_v[3];
   assign full0     = full_v[0];
   assign full1     = full_v[1];
   assign full2     = full_v[2];
   assign full3     = full_v[3];

endmodule

// File: tb/tb_demux_destinos.sv
// Directed bench for demux_destinos: reset, routing, fill/pause, full with
// simultaneous pop, illegal tags, pointer wrap and asynchronous reset.
module tb_demux_destinos;

   logic       clk = 1'b0;
   logic       reset_L;
   logic       push_in;
   logic [7:0] data_in;
   logic [3:0] dest_in;
   logic       pause_out;
   logic       pop0, pop1, pop2, pop3;
   logic [7:0] data_out0, data_out1, data_out2, data_out3;
   logic       empty0, empty1, empty2, empty3;
   logic       full0, full1, full2, full3;
   logic       err_dest, err_overflow;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_v;

   // clock/reset block
   always #5 clk = ~clk;

   demux_destinos dut (
      .clk(clk), .reset_L(reset_L), .push_in(push_in), .data_in(data_in),
      .dest_in(dest_in), .pause_out(pause_out),
      .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
      .data_out0(data_out0), .data_out1(data_out1),
      .data_out2(data_out2), .data_out3(data_out3),
      .empty0(empty0), .empty1(empty1), .empty2(empty2), .empty3(empty3),
      .full0(full0), .full1(full1), .full2(full2), .full3(full3),
      .err_dest(err_dest), .err_overflow(err_overflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // driver tasks
   task automatic idle();
      push_in = 1'b0; data_in = '0; dest_in = '0;
      pop0 = 1'b0; pop1 = 1'b0; pop2 = 1'b0; pop3 = 1'b0;
   endtask

   task automatic drive_push(input logic [7:0] d, input logic [3:0] t);
      push_in = 1'b1; data_in = d; dest_in = t;
   endtask

   initial begin
      idle();
      reset_L = 1'b0;
      step(); step();
      check("rst_empty", {empty3, empty2, empty1, empty0}, 4'b1111);
      check("rst_full", {full3, full2, full1, full0}, 4'b0000);
      check("rst_data", {data_out3, data_out2, data_out1, data_out0}, 32'h0);
      check("rst_pause", pause_out, 1'b0);
      check("rst_err", {err_dest, err_overflow}, 2'b00);
      reset_L = 1'b1;

      // popping an empty FIFO is silently ignored
      pop0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("idle_pop_empty0", empty0, 1'b1);
         check("idle_pop_err", {err_dest, err_overflow}, 2'b00);
      end
      idle();

      // routing
      drive_push(8'd10, 4'd0); step();
      check("route0_data", data_out0, 8'd10);
      check("route0_empty", {empty3, empty2, empty1, empty0}, 4'b1110);
      drive_push(8'd20, 4'd1); step();
      check("route1_data", data_out1, 8'd20);
      drive_push(8'd30, 4'd2); step();
      check("route2_data", data_out2, 8'd30);
      drive_push(8'd40, 4'd3); step();
      check("route3_data", data_out3, 8'd40);
      check("route_empty", {empty3, empty2, empty1, empty0}, 4'b0000);
      check("route_data0_kept", data_out0, 8'd10);
      idle();
      pop0 = 1'b1; pop1 = 1'b1; pop2 = 1'b1; pop3 = 1'b1;
      step();
      idle();
      check("route_drain_empty", {empty3, empty2, empty1, empty0}, 4'b1111);
      check("route_drain_data", {data_out3, data_out2, data_out1, data_out0}, 32'h0);

      // fill and pause on destination 1
      drive_push(8'd0, 4'd1); step();
      drive_push(8'd10, 4'd1); step();
      check("fill_pause_lo", pause_out, 1'b0);
      drive_push(8'd20, 4'd1); step();
      check("fill_pause_hi", pause_out, 1'b1);
      check("fill_not_full", full1, 1'b0);
      drive_push(8'd30, 4'd1); step();
      check("fill_full1", full1, 1'b1);
      check("fill_no_ovf", err_overflow, 1'b0);
      drive_push(8'd40, 4'd1); step();
      check("ovf_pulse", err_overflow, 1'b1);
      check("ovf_head", data_out1, 8'd0);
      check("ovf_full1", full1, 1'b1);
      idle(); step();
      check("ovf_pulse_end", err_overflow, 1'b0);
      pop1 = 1'b1;
      step(); check("drain1_a", data_out1, 8'd10);
      check("drain1_not_full", full1, 1'b0);
      step(); check("drain1_b", data_out1, 8'd20);
      check("drain1_pause_lo", pause_out, 1'b0);
      step(); check("drain1_c", data_out1, 8'd30);
      step(); check("drain1_empty", empty1, 1'b1);
      check("drain1_zero", data_out1, 8'd0);
      idle();

      // full FIFO accepts a push when popped on the same edge
      for (int i = 5; i <= 8; i++) begin
         drive_push(8'(i), 4'd2); step();
      end
      check("f2_full", full2, 1'b1);
      check("f2_head", data_out2, 8'd5);
      drive_push(8'd9, 4'd2); pop2 = 1'b1; step();
      check("f2_pp_full", full2, 1'b1);
      check("f2_pp_head", data_out2, 8'd6);
      check("f2_pp_no_ovf", err_overflow, 1'b0);
      idle();
      check("f2_seq_6", data_out2, 8'd6);
      pop2 = 1'b1;
      step(); check("f2_seq_7", data_out2, 8'd7);
      step(); check("f2_seq_8", data_out2, 8'd8);
      step(); check("f2_seq_9", data_out2, 8'd9);
      step(); check("f2_seq_empty", empty2, 1'b1);
      idle();

      // illegal tag
      drive_push(8'd55, 4'd7); step();
      check("bad_tag_pulse", err_dest, 1'b1);
      check("bad_tag_no_ovf", err_overflow, 1'b0);
      check("bad_tag_empty", {empty3, empty2, empty1, empty0}, 4'b1111);
      idle(); step();
      check("bad_tag_pulse_end", err_dest, 1'b0);

      // pointer wrap on destination 3
      for (int i = 0; i < 10; i++) begin
         exp_q.push_back(8'(8'd100 + 8'(i * 7)));
         drive_push(exp_q[$], 4'd3); step();
         idle();
         exp_v = exp_q.pop_front();
         check("wrap_head", data_out3, exp_v);
         pop3 = 1'b1; step(); idle();
         check("wrap_empty", empty3, 1'b1);
      end

      // asynchronous reset mid-stream
      drive_push(8'd77, 4'd0); step();
      drive_push(8'd88, 4'd0); step();
      idle();
      check("areset_pre", data_out0, 8'd77);
      #2 reset_L = 1'b0;
      #1;
      check("areset_empty0", empty0, 1'b1);
      check("areset_data0", data_out0, 8'd0);
      step();
      reset_L = 1'b1;
      step();
      check("areset_after", {empty3, empty2, empty1, empty0}, 4'b1111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
